ltc2333_ctrl: RTL and testbench

LTC2333_CTRL -- requirements
Module: ltc2333_ctrl

---
 rtl/ltc2333_ctrl_if.sv | 10 +
 rtl/ltc2333_ctrl.sv | 148 ++++++++++++++
 tb/tb_ltc2333_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ltc2333_ctrl_if.sv
// rtl/ltc2333_ctrl_if.sv - ADC pin bundle between ltc2333_ctrl (master) and the LTC2333 (slave)
interface ltc2333_ctrl_if;
    logic cnv;
    logic scki;
    logic sdi;
    logic busy;

    modport master (output cnv, output scki, output sdi, input busy);
    modport slave  (input cnv, input scki, input sdi, output busy);
endinterface

// File: rtl/ltc2333_ctrl.sv
// rtl/ltc2333_ctrl.sv - LTC2333 periodic conversion + SoftSpan/readout sequencer; busy sensing under LTC2333_CTRL_BUSY_EN
module ltc2333_ctrl #(
    parameter int CLK_DIV      = 2,
    parameter int CNV_HIGH     = 4,
    parameter int CONV_CYCLES  = 100,
    parameter int BUSY_TIMEOUT = 200
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [31:0]    period,
    input  logic [3:0]     n_ch,
    input  logic [23:0]    softspan,
    ltc2333_ctrl_if.master adc,
    output logic           done,
    output logic           overrun,
    output logic           timeout,
    output logic           active
);
    typedef enum logic [2:0] {IDLE, CNV, WAIT, SHIFT, DONE} state_t;

    localparam logic [31:0] MIN_PERIOD = 32'(CNV_HIGH + 24);
    localparam logic [31:0] CNV_LAST   = 32'(CNV_HIGH - 1);
    localparam logic [31:0] DIV_LAST   = 32'(CLK_DIV - 1);
    localparam logic [7:0]  MAX_BITS   = 8'd192;

    state_t      state, state_n;
    logic [31:0] per_cnt, per_reload, tmr;
    logic [3:0]  nch_q;
    logic [23:0] sh;
    logic [7:0]  bit_cnt, bit_total;
    logic        cnv_q, scki_q, sdi_q;
    logic        trigger, phase_end, last_bit, timeout_n, wait_done, wait_to;

    assign per_reload = ((period < MIN_PERIOD) ? MIN_PERIOD : period) - 32'd1;
    assign trigger    = enable && (per_cnt == 32'd0);
    assign bit_total  = {1'b0, nch_q, 3'b000} + {nch_q, 4'b0000};
    assign phase_end  = (tmr == DIV_LAST);
    assign last_bit   = ((bit_cnt + 8'd1) >= bit_total);

    assign adc.cnv  = cnv_q;
    assign adc.scki = scki_q;
    assign adc.sdi  = sdi_q;

`ifdef LTC2333_CTRL_BUSY_EN
    localparam logic [31:0] TO_LAST      = 32'(BUSY_TIMEOUT - 1);
    localparam int          unused_conv  = CONV_CYCLES;
    logic busy_s1, busy_s2, busy_seen;

    // busy_seen remembers that BUSY rose during this WAIT, so a later low means "conversion finished"
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_s1   <= 1'b0;
            busy_s2   <= 1'b0;
            busy_seen <= 1'b0;
        end else begin
            busy_s1   <= adc.busy;
            busy_s2   <= busy_s1;
            busy_seen <= (state == WAIT) && (busy_seen || busy_s2);
        end
    end

    assign wait_done = !busy_s2 && (busy_seen || (tmr >= 32'd7));
    assign wait_to   = (tmr >= TO_LAST);
`else
    localparam logic [31:0] CONV_LAST  = 32'(CONV_CYCLES - 1);
    localparam int          unused_to  = BUSY_TIMEOUT;
    logic unused_busy;

    assign unused_busy = adc.busy;
    assign wait_done   = (tmr >= CONV_LAST);
    assign wait_to     = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        timeout_n = 1'b0;
        case (state)
            IDLE:  if (trigger) state_n = CNV;
            CNV:   if (tmr >= CNV_LAST) state_n = WAIT;
            WAIT: begin
                if (wait_done) begin
                    state_n = SHIFT;
                end else if (wait_to) begin
                    state_n   = SHIFT;
                    timeout_n = 1'b1;
                end
            end
            SHIFT: if (phase_end && scki_q && last_bit) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            per_cnt <= per_reload;
            tmr     <= 32'd0;
            nch_q   <= 4'd0;
            sh      <= 24'd0;
            bit_cnt <= 8'd0;
            cnv_q   <= 1'b0;
            scki_q  <= 1'b0;
            sdi_q   <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
            timeout <= 1'b0;
            active  <= 1'b0;
        end else begin
            state   <= state_n;
            cnv_q   <= (state_n == CNV);
            active  <= (state_n != IDLE);
            done    <= (state_n == DONE);
            overrun <= trigger && (state != IDLE);
            timeout <= timeout_n;

            if (!enable || (per_cnt == 32'd0)) per_cnt <= per_reload;
            else                              per_cnt <= per_cnt - 32'd1;

            // tmr counts cycles within a state, and within an SCKI half-period while shifting
            if ((state_n != state) || (state == IDLE) || ((state == SHIFT) && phase_end)) tmr <= 32'd0;
            else                                                                     tmr <= tmr + 32'd1;

            if ((state == IDLE) && trigger) begin
                nch_q <= ((n_ch == 4'd0) || (n_ch > 4'd8)) ? 4'd8 : n_ch;
                sh    <= softspan;
            end

            if ((state_n == SHIFT) && (state != SHIFT)) begin
                scki_q  <= 1'b0;
                sdi_q   <= sh[23];
                sh      <= {sh[22:0], 1'b0};
                bit_cnt <= 8'd0;
            end else if ((state == SHIFT) && (state_n == SHIFT) && phase_end) begin
                scki_q <= !scki_q;
                if (scki_q) begin
                    sdi_q   <= sh[23];
                    sh      <= {sh[22:0], 1'b0};
                    bit_cnt <= (bit_cnt < MAX_BITS) ? (bit_cnt + 8'd1) : MAX_BITS;
                end
            end else if (state_n != SHIFT) begin
                scki_q <= 1'b0;
                sdi_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ltc2333_ctrl.sv
// tb/tb_ltc2333_ctrl.sv - randomized bench for ltc2333_ctrl against a per-cycle waveform model built from transaction rules
module tb_ltc2333_ctrl;
    localparam int CLK_DIV      = 2;
    localparam int CNV_HIGH     = 4;
    localparam int CONV_CYCLES  = 100;
    localparam int BUSY_TIMEOUT = 200;
    localparam int MAXC         = 65536;
`ifdef LTC2333_CTRL_BUSY_EN
    localparam int WAIT_DEF = 8;
`else
    localparam int WAIT_DEF = CONV_CYCLES;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] period = 32'd1000;
    logic [3:0]  n_ch = 4'd1;
    logic [23:0] softspan = 24'd0;
    logic        busy_drv = 1'b0;
    logic        done, overrun, timeout, active;

    ltc2333_ctrl_if adc();
    assign adc.busy = busy_drv;

    ltc2333_ctrl #(
        .CLK_DIV(CLK_DIV), .CNV_HIGH(CNV_HIGH), .CONV_CYCLES(CONV_CYCLES), .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .period(period), .n_ch(n_ch),
        .softspan(softspan), .adc(adc), .done(done), .overrun(overrun),
        .timeout(timeout), .active(active)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          last_rst_edge = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          mdl_busy_end;
    int          mdl_top;
    logic        in_rst  [MAXC];
    logic        in_en   [MAXC];
    logic        in_busy [MAXC];
    logic [31:0] in_per  [MAXC];
    logic [3:0]  in_nch  [MAXC];
    logic [23:0] in_ss   [MAXC];
    logic [6:0]  obs     [MAXC];
    logic [6:0]  expv    [MAXC];

    // index e = value sampled by the design at posedge number e
    always @(posedge clk) begin
        if (cyc < MAXC - 1) begin
            cyc = cyc + 1;
            in_rst[cyc]  = reset;
            in_en[cyc]   = enable;
            in_busy[cyc] = busy_drv;
            in_per[cyc]  = period;
            in_nch[cyc]  = n_ch;
            in_ss[cyc]   = softspan;
            if (reset) last_rst_edge = cyc;
        end
    end

    // bits: cnv scki sdi done overrun timeout active
    always @(negedge clk) obs[cyc] = {adc.cnv, adc.scki, adc.sdi, done, overrun, timeout, active};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic restart(input logic [31:0] p, input logic [3:0] n, input logic [23:0] ss);
        reset = 1'b1;
        tick(3);
        period = p; n_ch = n; softspan = ss; enable = 1'b1; busy_drv = 1'b0;
        tick(1);
        reset = 1'b0;
    endtask

    // WAIT length from the busy rules; synchronized busy in cycle c is the pin sampled at edge c-1
    task automatic wait_len(input int w0, output int w, output logic to);
`ifdef LTC2333_CTRL_BUSY_EN
        logic seen;
        logic b;
        seen = 1'b0;
        to = 1'b1;
        w = BUSY_TIMEOUT;
        for (int j = 0; j < BUSY_TIMEOUT; j++) begin
            b = in_busy[w0 + j - 1];
            if (b === 1'b1) seen = 1'b1;
            if ((b === 1'b0) && (seen || j >= 7)) begin
                w = j + 1;
                to = 1'b0;
                return;
            end
        end
`else
        w = CONV_CYCLES;
        to = 1'b0;
`endif
    endtask

    task automatic start_txn(input int s);
        int n, w, sh0, d, o, k;
        logic to;
        logic [23:0] ss;
        n   = ((in_nch[s] == 4'd0) || (in_nch[s] > 4'd8)) ? 8 : int'(in_nch[s]);
        ss  = in_ss[s];
        wait_len(s + CNV_HIGH, w, to);
        sh0 = s + CNV_HIGH + w;
        d   = sh0 + 48 * CLK_DIV * n;
        for (int c = s; c <= d && c < MAXC; c++) begin
            expv[c][0] = 1'b1;
            if (c < s + CNV_HIGH) expv[c][6] = 1'b1;
            if (c >= sh0 && c < d) begin
                o = c - sh0;
                k = o / (2 * CLK_DIV);
                expv[c][5] = ((o % (2 * CLK_DIV)) >= CLK_DIV);
                expv[c][4] = (k < 24) ? ss[23 - k] : 1'b0;
            end
        end
        if (to && sh0 < MAXC) expv[sh0][1] = 1'b1;
        if (d < MAXC) expv[d][3] = 1'b1;
        mdl_busy_end = d + 2;
        mdl_top = d;
    endtask

    task automatic build_model(input int last);
        int anchor, peff;
        anchor = 0;
        mdl_busy_end = 0;
        mdl_top = 0;
        for (int c = 0; c < MAXC; c++) expv[c] = '0;
        for (int e = 1; e <= last; e++) begin
            if (in_rst[e]) begin
                for (int c = e; c <= mdl_top && c < MAXC; c++) expv[c] = '0;
                anchor = e;
                mdl_busy_end = 0;
            end else begin
                peff = (in_per[e] < 32'(CNV_HIGH + 24)) ? (CNV_HIGH + 24) : int'(in_per[e]);
                if (in_en[e] && e > anchor && ((e - anchor) % peff) == 0) begin
                    if (e >= mdl_busy_end) start_txn(e);
                    else                   expv[e][2] = 1'b1;
                end
                if (!in_en[e]) anchor = e;
            end
        end
    endtask

    initial begin
        int s, h, last, od, ed, oo, eo, ot, et;
        tick(4);
        restart(32'd1000, 4'd1, 24'hFFFFFF);   tick(3200);
        restart(32'd1000, 4'd8, 24'h800001);   tick(3000);
        restart(32'd1000, 4'd0, 24'h5A5A5A);   tick(1100);
        restart(32'd1000, 4'd12, 24'hA5A5A5);  tick(1100);
        restart(32'd100, 4'd8, 24'hC3C3C3);    tick(2800);
        restart(32'd5, 4'd1, 24'h123456);      tick(800);

        // reset lands on the first high cycle of the 10th SCKI pulse
        restart(32'd300, 4'd2, 24'hF0F0F0);
        s = last_rst_edge + 300;
        while (cyc < s + CNV_HIGH + WAIT_DEF + 38) tick(1);
        reset = 1'b1; tick(2); reset = 1'b0; tick(1000);

        restart(32'd400, 4'd3, 24'h0F0F0F);
        s = last_rst_edge + 400;
        while (cyc < s + 150) tick(1);
        enable = 1'b0; tick(700); enable = 1'b1; tick(1300);

        for (int r = 0; r < 4; r++) begin
            restart($urandom_range(10, 1200), 4'($urandom_range(0, 15)), 24'($urandom));
            for (int t = 0; t < 4000; t += h) begin
                h = $urandom_range(30, 400);
                tick(h);
                n_ch = 4'($urandom_range(0, 15));
                softspan = 24'($urandom);
                if ($urandom_range(0, 9) == 0) enable = ~enable;
            end
        end

`ifdef LTC2333_CTRL_BUSY_EN
        restart(32'd2000, 4'd1, 24'hABCDEF);
        s = last_rst_edge + 2000;
        while (cyc < s) tick(1);
        busy_drv = 1'b1; tick(600); busy_drv = 1'b0; tick(1500);

        restart(32'd2000, 4'd2, 24'h13579B);
        s = last_rst_edge + 2000;
        while (cyc < s) tick(1);
        busy_drv = 1'b1; tick(54); busy_drv = 1'b0; tick(2500);
`endif

        tick(2);
        last = cyc - 1;
        build_model(last);
        od = 0; ed = 0; oo = 0; eo = 0; ot = 0; et = 0;
        for (int c = 1; c <= last; c++) begin
            check($sformatf("pins_cyc%0d", c), 32'(obs[c]), 32'(expv[c]));
            od += int'(obs[c][3]);  ed += int'(expv[c][3]);
            oo += int'(obs[c][2]);  eo += int'(expv[c][2]);
            ot += int'(obs[c][1]);  et += int'(expv[c][1]);
        end
        check("done_pulse_count", 32'(od), 32'(ed));
        check("overrun_pulse_count", 32'(oo), 32'(eo));
        check("timeout_pulse_count", 32'(ot), 32'(et));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
